// File: rtl/alu_op_issuer_pkg.sv
// alu_op_issuer_pkg: shared widths, funct / ALU operation codes and issuer
// state type. Stands in for the legacy prj_definition.v include. The `DATA_WIDTH
// family of macros is kept for older files that still reference it.
// Optional feature macro (used in alu_op_issuer.sv): ALU_ISSUER_BACK2BACK_EN.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_INDEX_LIMIT
`define DATA_INDEX_LIMIT 31
`endif
`ifndef ALU_OPRN_WIDTH
`define ALU_OPRN_WIDTH 6
`endif
`ifndef ALU_OPRN_INDEX_LIMIT
`define ALU_OPRN_INDEX_LIMIT 5
`endif

package alu_op_issuer_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ALU_OPRN_WIDTH = 6;
    localparam int unsigned FUNCT_WIDTH    = 6;
    localparam int unsigned SHAMT_WIDTH    = 5;

    // R-type funct field values
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MUL = 6'h2C;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL = 6'h02;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL = 6'h00;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NOR = 6'h27;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SRL = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLL = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

    // Issuer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issuer_state_e;

    // Shift amount as the second ALU operand
    function automatic logic [DATA_WIDTH-1:0] shamt_operand(input logic [SHAMT_WIDTH-1:0] shamt);
        return DATA_WIDTH'(shamt);
    endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: command, ALU and response signals of the issuer.
// master = issuer side, slave = surrounding control/datapath and ALU.

interface alu_op_issuer_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    import alu_op_issuer_pkg::*;

    logic                      CMD_VALID;
    logic                      CMD_READY;
    logic [FUNCT_WIDTH-1:0]    CMD_FUNCT;
    logic [SHAMT_WIDTH-1:0]    CMD_SHAMT;
    logic [DATA_WIDTH-1:0]     CMD_OP1;
    logic [DATA_WIDTH-1:0]     CMD_OP2;
    logic [DATA_WIDTH-1:0]     ALU_OP1;
    logic [DATA_WIDTH-1:0]     ALU_OP2;
    logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN;
    logic [DATA_WIDTH-1:0]     ALU_RESULT;
    logic                      RSP_VALID;
    logic                      RSP_READY;
    logic [DATA_WIDTH-1:0]     RSP_DATA;
    logic                      RSP_ERR;
    logic [CNT_WIDTH-1:0]      ISSUE_CNT;

    modport master (
        input  CMD_VALID, CMD_FUNCT, CMD_SHAMT, CMD_OP1, CMD_OP2,
        input  ALU_RESULT, RSP_READY,
        output CMD_READY, ALU_OP1, ALU_OP2, ALU_OPRN,
        output RSP_VALID, RSP_DATA, RSP_ERR, ISSUE_CNT
    );

    modport slave (
        output CMD_VALID, CMD_FUNCT, CMD_SHAMT, CMD_OP1, CMD_OP2,
        output ALU_RESULT, RSP_READY,
        input  CMD_READY, ALU_OP1, ALU_OP2, ALU_OPRN,
        input  RSP_VALID, RSP_DATA, RSP_ERR, ISSUE_CNT
    );

endinterface

// File: rtl/alu_op_issuer_funct_to_oprn.sv
// funct_to_oprn: combinational decode of the R-type funct field into an ALU
// operation code, a shift flag (second operand comes from shamt) and a valid flag.

module funct_to_oprn
    import alu_op_issuer_pkg::*;
(
    input  logic [FUNCT_WIDTH-1:0]    funct,
    output logic [ALU_OPRN_WIDTH-1:0] oprn,
    output logic                      is_shift,
    output logic                      valid
);

    // Map funct to operation code; unknown funct flags invalid
    always_comb begin
        oprn     = '0;
        is_shift = 1'b0;
        valid    = 1'b1;
        case (funct)
            FUNCT_ADD: oprn = ALU_OPRN_ADD;
            FUNCT_SUB: oprn = ALU_OPRN_SUB;
            FUNCT_MUL: oprn = ALU_OPRN_MUL;
            FUNCT_SRL: begin
                oprn     = ALU_OPRN_SRL;
                is_shift = 1'b1;
            end
            FUNCT_SLL: begin
                oprn     = ALU_OPRN_SLL;
                is_shift = 1'b1;
            end
            FUNCT_AND: oprn = ALU_OPRN_AND;
            FUNCT_OR:  oprn = ALU_OPRN_OR;
            FUNCT_NOR: oprn = ALU_OPRN_NOR;
            FUNCT_SLT: oprn = ALU_OPRN_SLT;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: accepts an R-type command, registers the ALU inputs, captures
// the combinational ALU result one cycle later and returns it on a response
// handshake. Unsupported funct answers immediately with RSP_ERR set.
// Optional macro ALU_ISSUER_BACK2BACK_EN: accept the next command on the same
// edge as the response handshake.

module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    alu_op_issuer_if.master  bus
);

    issuer_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]     alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0]     alu_op2_q, alu_op2_d;
    logic [ALU_OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [CNT_WIDTH-1:0]      issue_cnt_q, issue_cnt_d;

    logic                      cmd_ready;
    logic [ALU_OPRN_WIDTH-1:0] dec_oprn;
    logic                      dec_is_shift;
    logic                      dec_valid;

    funct_to_oprn u_funct_to_oprn (
        .funct    (bus.CMD_FUNCT),
        .oprn     (dec_oprn),
        .is_shift (dec_is_shift),
        .valid    (dec_valid)
    );

    // Next-state and datapath: state actions first, then command acceptance,
    // which overrides the RESP->IDLE return when back-to-back is enabled
    always_comb begin
        state_d     = state_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_oprn_d  = alu_oprn_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        issue_cnt_d = issue_cnt_q;

        cmd_ready = (state_q == ST_IDLE);
`ifdef ALU_ISSUER_BACK2BACK_EN
        cmd_ready = cmd_ready | ((state_q == ST_RESP) & bus.RSP_READY);
`endif

        case (state_q)
            ST_ISSUE: begin
                rsp_data_d  = bus.ALU_RESULT;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (bus.CMD_VALID && cmd_ready) begin
            if (dec_valid) begin
                alu_op1_d   = bus.CMD_OP1;
                alu_op2_d   = dec_is_shift ? shamt_operand(bus.CMD_SHAMT) : bus.CMD_OP2;
                alu_oprn_d  = dec_oprn;
                rsp_valid_d = 1'b0;
                state_d     = ST_ISSUE;
            end else begin
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_oprn_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_oprn_q  <= alu_oprn_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign bus.CMD_READY = cmd_ready;
    assign bus.ALU_OP1   = alu_op1_q;
    assign bus.ALU_OP2   = alu_op2_q;
    assign bus.ALU_OPRN  = alu_oprn_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.ISSUE_CNT = issue_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed vector table, backpressure / reset / back-to-back
// sequences and a randomized run against a funct-level reference model.

module tb_alu_op_issuer;
    import alu_op_issuer_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    alu_op_issuer_if #(.CNT_WIDTH(CNT_W)) bus ();

    alu_op_issuer #(.CNT_WIDTH(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Combinational ALU standing in for the real ALU instance
    function automatic logic [31:0] alu_model(input logic [5:0] oprn, input logic [31:0] a, input logic [31:0] b);
        case (oprn)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a * b;
            6'h04: return a >> b;
            6'h05: return a << b;
            6'h06: return a & b;
            6'h07: return a | b;
            6'h08: return ~(a | b);
            6'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.ALU_RESULT = alu_model(bus.ALU_OPRN, bus.ALU_OP1, bus.ALU_OP2);

    // Reference: what an R-type instruction computes, straight from funct
    function automatic void ref_model(input logic [5:0] f, input logic [4:0] sh,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic ok, output logic [31:0] r);
        ok = 1'b1;
        r  = 32'd0;
        case (f)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h2C: r = a * b;
            6'h02: r = a >> sh;
            6'h00: r = a << sh;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h27: r = ~(a | b);
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a command at a negedge, wait for acceptance, then for the response.
    // Returns the number of negedges from acceptance until RSP_VALID was seen.
    task automatic send_cmd(input logic [5:0] f, input logic [4:0] sh,
                            input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        int w;
        bus.CMD_VALID = 1'b1;
        bus.CMD_FUNCT = f;
        bus.CMD_SHAMT = sh;
        bus.CMD_OP1   = a;
        bus.CMD_OP2   = b;
        w = 0;
        while (!bus.CMD_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 50) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        bus.CMD_FUNCT = 6'($urandom());
        bus.CMD_SHAMT = 5'($urandom());
        bus.CMD_OP1   = $urandom();
        bus.CMD_OP2   = $urandom();
        lat = 0;
        while (!bus.RSP_VALID && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        if (lat >= 50) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_rsp();
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.RSP_READY = 1'b0;
        check("rsp_drop", 32'(bus.RSP_VALID), 32'd0);
        check("ready_after_rsp", 32'(bus.CMD_READY), 32'd1);
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [5:0]  exp_oprn;
        logic [31:0] exp_op2;
    } vec_t;

    vec_t vecs [12];
    logic [5:0] valid_functs [9];

    initial begin
        logic [31:0] e_op1, e_op2;
        logic [5:0]  e_oprn;
        int          lat;
        int          hold;
        logic        ok;
        logic [31:0] r;

        vecs[0]  = '{6'h20, 5'd0,  32'd5,        32'd7,        32'd12,       1'b0, 6'h01, 32'd7};
        vecs[1]  = '{6'h00, 5'd4,  32'h1,        32'hDEAD,     32'h10,       1'b0, 6'h05, 32'd4};
        vecs[2]  = '{6'h02, 5'd31, 32'h80000000, 32'h1234,     32'd1,        1'b0, 6'h04, 32'd31};
        vecs[3]  = '{6'h2A, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 6'h09, 32'd1};
        vecs[4]  = '{6'h3F, 5'd3,  32'h1,        32'h2,        32'd0,        1'b1, 6'h00, 32'd0};
        vecs[5]  = '{6'h22, 5'd0,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 6'h02, 32'd5};
        vecs[6]  = '{6'h2C, 5'd0,  32'h10000,    32'h10001,    32'h00010000, 1'b0, 6'h03, 32'h10001};
        vecs[7]  = '{6'h24, 5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 6'h06, 32'h0FF00FF0};
        vecs[8]  = '{6'h25, 5'd0,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 6'h07, 32'h0000000F};
        vecs[9]  = '{6'h27, 5'd0,  32'h0,        32'hFFFF0000, 32'h0000FFFF, 1'b0, 6'h08, 32'hFFFF0000};
        vecs[10] = '{6'h01, 5'd9,  32'h77,       32'h88,       32'd0,        1'b1, 6'h00, 32'd0};
        vecs[11] = '{6'h2A, 5'd0,  32'd5,        32'hFFFFFFFE, 32'd0,        1'b0, 6'h09, 32'hFFFFFFFE};
        valid_functs = '{6'h20, 6'h22, 6'h2C, 6'h02, 6'h00, 6'h24, 6'h25, 6'h27, 6'h2A};

        bus.CMD_VALID = 1'b0;
        bus.CMD_FUNCT = '0;
        bus.CMD_SHAMT = '0;
        bus.CMD_OP1   = '0;
        bus.CMD_OP2   = '0;
        bus.RSP_READY = 1'b0;
        e_op1 = '0; e_op2 = '0; e_oprn = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("rst_rsp_data",  bus.RSP_DATA,       32'd0);
        check("rst_rsp_err",   32'(bus.RSP_ERR),   32'd0);
        check("rst_alu_op1",   bus.ALU_OP1,        32'd0);
        check("rst_alu_op2",   bus.ALU_OP2,        32'd0);
        check("rst_alu_oprn",  32'(bus.ALU_OPRN),  32'd0);
        check("rst_issue_cnt", 32'(bus.ISSUE_CNT), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            send_cmd(vecs[i].f, vecs[i].sh, vecs[i].a, vecs[i].b, lat);
            if (!vecs[i].exp_err) begin
                e_op1  = vecs[i].a;
                e_op2  = vecs[i].exp_op2;
                e_oprn = vecs[i].exp_oprn;
                exp_cnt = exp_cnt + 1'b1;
            end
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd0 : 32'd1);
            check($sformatf("v%0d_data", i),    bus.RSP_DATA,       vecs[i].exp_data);
            check($sformatf("v%0d_err", i),     32'(bus.RSP_ERR),   32'(vecs[i].exp_err));
            check($sformatf("v%0d_alu_op1", i), bus.ALU_OP1,        e_op1);
            check($sformatf("v%0d_alu_op2", i), bus.ALU_OP2,        e_op2);
            check($sformatf("v%0d_oprn", i),    32'(bus.ALU_OPRN),  32'(e_oprn));
            check($sformatf("v%0d_cnt", i),     32'(bus.ISSUE_CNT), 32'(exp_cnt));
            hold = (i == 4) ? 5 : 1;
            for (int k = 0; k < hold; k++) begin
                @(negedge CLK);
                check($sformatf("v%0d_hold_valid", i), 32'(bus.RSP_VALID), 32'd1);
                check($sformatf("v%0d_hold_data", i),  bus.RSP_DATA,       vecs[i].exp_data);
                check($sformatf("v%0d_hold_err", i),   32'(bus.RSP_ERR),   32'(vecs[i].exp_err));
                check($sformatf("v%0d_hold_ready", i), 32'(bus.CMD_READY), 32'd0);
            end
            finish_rsp();
        end

        // Reset while a response is pending
        send_cmd(6'h20, 5'd0, 32'd100, 32'd23, lat);
        check("mid_rst_pre_valid", 32'(bus.RSP_VALID), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.RSP_VALID), 32'd0);
        check("mid_rst_cnt",   32'(bus.ISSUE_CNT), 32'd0);
        check("mid_rst_oprn",  32'(bus.ALU_OPRN),  32'd0);
        exp_cnt = '0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.CMD_READY), 32'd1);
        @(negedge CLK);

        // Two adds with the consumer always ready: response spacing
        begin
            int sent, rsp_n, t0, t1;
            logic [31:0] d0, d1;
            bit acc;
            sent = 0; rsp_n = 0; acc = 1'b0; t0 = 0; t1 = 0; d0 = '0; d1 = '0;
            bus.RSP_READY = 1'b1;
            bus.CMD_VALID = 1'b1;
            bus.CMD_FUNCT = 6'h20; bus.CMD_SHAMT = '0;
            bus.CMD_OP1 = 32'd1;   bus.CMD_OP2 = 32'd2;
            for (int c = 0; c < 30 && rsp_n < 2; c++) begin
                if (acc) begin
                    sent++;
                    acc = 1'b0;
                    if (sent == 1) begin
                        bus.CMD_OP1 = 32'd3;
                        bus.CMD_OP2 = 32'd4;
                    end else begin
                        bus.CMD_VALID = 1'b0;
                    end
                end
                if (bus.RSP_VALID) begin
                    if (rsp_n == 0) begin t0 = c; d0 = bus.RSP_DATA; end
                    else            begin t1 = c; d1 = bus.RSP_DATA; end
                    rsp_n++;
                end
                if (bus.CMD_VALID && bus.CMD_READY) acc = 1'b1;
                @(negedge CLK);
            end
            bus.CMD_VALID = 1'b0;
            exp_cnt = exp_cnt + 2'd2;
            check("b2b_rsp_count", 32'(rsp_n), 32'd2);
            check("b2b_rsp0",      d0,         32'd3);
            check("b2b_rsp1",      d1,         32'd7);
`ifdef ALU_ISSUER_BACK2BACK_EN
            check("b2b_spacing",   32'(t1 - t0), 32'd2);
`else
            check("b2b_spacing",   32'(t1 - t0), 32'd3);
`endif
            check("b2b_cnt",       32'(bus.ISSUE_CNT), 32'(exp_cnt));
            bus.RSP_READY = 1'b0;
            @(negedge CLK);
        end

        // Randomized commands against the funct-level reference
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  f;
            logic [4:0]  sh;
            logic [31:0] a, b;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            f  = (sel < 9) ? valid_functs[sel] : 6'($urandom_range(0, 63));
            sh = 5'($urandom());
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            bus.RSP_READY = 1'($urandom_range(0, 1));
            ref_model(f, sh, a, b, ok, r);
            send_cmd(f, sh, a, b, lat);
            if (ok) exp_cnt = exp_cnt + 1'b1;
            check($sformatf("r%0d_f%02h_data", n, f), bus.RSP_DATA,       r);
            check($sformatf("r%0d_f%02h_err", n, f),  32'(bus.RSP_ERR),   32'(!ok));
            check($sformatf("r%0d_latency", n),       32'(lat),           ok ? 32'd1 : 32'd0);
            check($sformatf("r%0d_cnt", n),           32'(bus.ISSUE_CNT), 32'(exp_cnt));
            finish_rsp();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Sequential initiator for the combinational 32-bit ALU. It accepts an R-type command (funct, shamt, two operands) over a valid/ready handshake.
- It decodes funct into the ALU operation code, drives the ALU inputs from registers and captures the ALU result one cycle later.
- It returns the result over a second valid/ready handshake.
- It sits between the processor control/datapath and the ALU instance.

Parameters:
- CNT_WIDTH, 16, width of the issued-operation counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  issuer can accept a command.
- CMD_FUNCT  input  6  R-type funct field.
- CMD_SHAMT  input  5  shift amount.
- CMD_OP1  input  `DATA_WIDTH  operand 1.
- CMD_OP2  input  `DATA_WIDTH  operand 2.
- ALU_OP1  output  `DATA_WIDTH  registered ALU operand 1.
- ALU_OP2  output  `DATA_WIDTH  registered ALU operand 2.
- ALU_OPRN  output  `ALU_OPRN_WIDTH  registered ALU operation code.
- ALU_RESULT  input  `DATA_WIDTH  combinational ALU result.
- RSP_VALID  output  1  response present.
- RSP_READY  input  1  consumer accepts response.
- RSP_DATA  output  `DATA_WIDTH  captured result.
- RSP_ERR  output  1  unsupported funct.
- ISSUE_CNT  output  CNT_WIDTH  count of ALU operations issued.

Behaviour:
- Clocking and reset:
  - One clock CLK.
  - RST is asynchronous, active-low; when low, all state is cleared immediately.
  - Reset values: state IDLE, ALU_OP1/ALU_OP2/ALU_OPRN = 0, RSP_VALID = 0, RSP_DATA = 0, RSP_ERR = 0, ISSUE_CNT = 0.
- States: IDLE, ISSUE, RESP.
- CMD_READY = (state == IDLE). It is combinational from state.
- funct decode (funct -> oprn):
  - 0x20 add -> 0x01; 0x22 sub -> 0x02; 0x2C mul -> 0x03.
  - 0x02 srl -> 0x04; 0x00 sll -> 0x05.
  - 0x24 and -> 0x06; 0x25 or -> 0x07; 0x27 nor -> 0x08.
  - 0x2A slt -> 0x09.
  - Any other funct is invalid.
- IDLE, on an edge with CMD_VALID & CMD_READY and a valid funct:
  - ALU_OP1 <= CMD_OP1.
  - ALU_OP2 <= CMD_SHAMT zero-extended to 32 bits for srl/sll; otherwise ALU_OP2 <= CMD_OP2.
  - ALU_OPRN <= decoded code.
  - Next state ISSUE.
- IDLE, on an edge with CMD_VALID & CMD_READY and an invalid funct:
  - ALU_* registers are unchanged.
  - RSP_DATA <= 0, RSP_ERR <= 1, RSP_VALID <= 1.
  - Next state RESP; ISSUE_CNT does not increment.
- ISSUE (exactly one cycle; the ALU settles):
  - At the next edge: RSP_DATA <= ALU_RESULT, RSP_ERR <= 0, RSP_VALID <= 1.
  - ISSUE_CNT <= ISSUE_CNT + 1, wrapping modulo 2^CNT_WIDTH.
  - Next state RESP.
- RESP:
  - RSP_VALID, RSP_DATA and RSP_ERR are held stable until an edge with RSP_READY = 1.
  - On that edge: RSP_VALID <= 0, next state IDLE.
- Latency: the response is visible one cycle after command acceptance (two for ALU-valid data path timing). Base throughput is one command per 3 cycles.
- ALU_* registers hold their last values between commands. They are not cleared at the response handshake.
- CMD_* inputs are sampled only at acceptance; changes at any other time are ignored.
- RSP_READY held high while in IDLE or ISSUE has no effect.
- Reset mid-operation (ISSUE or RESP) aborts:
  - The pending response is discarded; RSP_VALID = 0.
  - ISSUE_CNT = 0.

Optional Feature:
- Macro: ALU_ISSUER_BACK2BACK_EN.
- Defined:
  - CMD_READY = (state == IDLE) | (state == RESP & RSP_READY).
  - A command accepted on the same edge as the response handshake is processed exactly as from IDLE: next state ISSUE, or RESP with RSP_ERR=1 if funct is invalid.
  - RSP_VALID stays 1 only in the invalid case; in the valid case it drops for the ISSUE cycle.
  - Throughput: one command per 2 cycles.
- Not defined: CMD_READY is asserted only in IDLE.

Decomposition:
- Shared include prj_definition.v supplies:
  - `DATA_WIDTH, `DATA_INDEX_LIMIT, `ALU_OPRN_WIDTH, `ALU_OPRN_INDEX_LIMIT.
  - New funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_SRL, FUNCT_SLL, FUNCT_AND, FUNCT_OR, FUNCT_NOR, FUNCT_SLT).
  - ALU_OPRN_* code constants.
  - Issuer state encodings.
- One natural sub-module: funct_to_oprn.
  - Purely combinational decode.
  - Outputs: oprn[6], is_shift, valid.
  - Instantiated once in alu_op_issuer.

Test Plan:
- Reset and add: reset, then command funct=0x20, op1=5, op2=7 -> ALU_OPRN=0x01; after ISSUE: RSP_VALID=1, RSP_DATA=12, RSP_ERR=0, ISSUE_CNT=1.
- Shift uses shamt: funct=0x00, op1=0x1, op2=0xDEAD, shamt=4 -> ALU_OP2=4, RSP_DATA=0x10; funct=0x02, op1=0x80000000, shamt=31 -> RSP_DATA=1.
- slt with negative operand: funct=0x2A, op1=0xFFFFFFFF, op2=1 -> RSP_DATA=1.
- Invalid funct and backpressure:
  - funct=0x3F -> RSP_ERR=1, RSP_DATA=0, ISSUE_CNT unchanged, ALU_* unchanged.
  - Hold RSP_READY=0 for 5 cycles -> response stable, CMD_READY=0.
  - Raise RSP_READY -> IDLE.
- Reset mid-operation: assert RST low while in RESP -> RSP_VALID=0 immediately, ISSUE_CNT=0, CMD_READY=1 after release.
- Back-to-back with macro defined: two adds (1+2, 3+4) with RSP_READY=1 -> responses 3 and 7 on cycles 2 apart, ISSUE_CNT=2; macro undefined -> spacing 3 cycles.
